// File: rtl/twos_inc_serial.sv
// Bit-serial "+1" stage completing two's-complement negation: adds one to the
// one's-complement word LSB-first with a single carry flop, then hands off the result.
module twos_inc_serial #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 4
) (
    input  logic             t_clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic             c;
    logic [CNT_W-1:0] cnt;

    // Half adder for one serial bit: {carry, sum}.
    function automatic logic [1:0] half_add(input logic b, input logic cin);
        half_add = {b & cin, b ^ cin};
    endfunction

    logic [1:0] ha;
    assign ha = half_add(sr[0], c);

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr       <= in_data;
                        c        <= 1'b1;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    // Sum bit enters at the top, so after WIDTH shifts sr holds the result in order.
                    sr  <= {ha[0], sr[WIDTH-1:1]};
                    c   <= ha[1];
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // sr and c are deliberately left as-is after the handoff.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = sr;
    assign out_ovf  = c;

endmodule

// File: tb/tb_twos_inc_serial.sv
// Directed bench for twos_inc_serial: reset, value sweep, backpressure,
// reset during RUN and a back-to-back stream with initiation-interval check.
module tb_twos_inc_serial;

    logic        t_clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_ovf;
    logic        busy;

    int errs = 0;
    int nchk = 0;
    int cyc  = 0;

    twos_inc_serial #(.WIDTH(12), .CNT_W(4)) dut (
        .t_clk     (t_clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial begin
        t_clk = 1'b0;
        forever #5 t_clk = ~t_clk;
    end

    always @(posedge t_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge t_clk);
        #1;
    endtask

    // Wait (bounded) for out_valid; returns cycles waited, 99 on timeout.
    task automatic wait_out(output int lat);
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    // One word through with out_ready held high; acceptance on the next edge.
    task automatic do_word(input logic [11:0] d, input logic [11:0] exp_d,
                           input logic exp_ovf, input string tag);
        int lat;
        in_data  = d;
        in_valid = 1'b1;
        chk({tag, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        wait_out(lat);
        chk({tag, "_lat"}, lat, 12);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_ovf"}, out_ovf, exp_ovf);
        tick();
        chk({tag, "_rdy_after"}, in_ready, 1);
        chk({tag, "_vld_after"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int acc, prev_acc;
        logic seen;
        logic [11:0] w;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 12'h000;
        out_ready = 1'b1;

        // Asynchronous reset asserted between edges
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 12'h000);
        chk("rst_out_ovf", out_ovf, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Accepted on the first edge after release
        do_word(12'h000, 12'h001, 1'b0, "zero");
        do_word(12'hFFF, 12'h000, 1'b1, "allones");
        do_word(12'h7FF, 12'h800, 1'b0, "maxpos");
        do_word(12'hFFE, 12'hFFF, 1'b0, "fffe");

        // Backpressure in DONE with a competing input
        out_ready = 1'b0;
        in_data   = 12'h5A5;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        wait_out(lat);
        chk("bp_lat", lat, 12);
        in_data = 12'h123;
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_data", out_data, 12'h5A6);
            chk("bp_ovf", out_ovf, 0);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("bp_handoff_rdy", in_ready, 1);
        chk("bp_handoff_busy", busy, 0);
        chk("bp_handoff_vld", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("bp_next_busy", busy, 1);
        wait_out(lat);
        chk("bp_next_lat", lat, 12);
        chk("bp_next_data", out_data, 12'h124);
        tick();

        // Reset on the 6th RUN cycle
        in_data  = 12'h0AA;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("rr_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_busy", busy, 0);
        chk("rr_in_ready", in_ready, 1);
        chk("rr_out_valid", out_valid, 0);
        chk("rr_out_data", out_data, 12'h000);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("rr_no_valid", seen, 0);
        do_word(12'h00F, 12'h010, 1'b0, "after_rst");

        // Back-to-back stream, in_valid held high
        prev_acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            w = 12'($urandom_range(0, 4095));
            if (i == 7) w = 12'hFFF;
            in_data = w;
            tick();
            acc = cyc;
            chk("b2b_busy", busy, 1);
            if (i > 0) chk("b2b_spacing", acc - prev_acc, 14);
            prev_acc = acc;
            wait_out(lat);
            chk("b2b_lat", lat, 12);
            chk("b2b_data", out_data, (w + 12'd1) & 12'hFFF);
            chk("b2b_ovf", out_ovf, (w == 12'hFFF) ? 1 : 0);
            tick();
            chk("b2b_rdy", in_ready, 1);
        end
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
